avmm_rw_mem_responder: RTL and testbench
========================================

// Module: avmm_rw_mem_responder
// PURPOSE
//  Avalon-MM responder (slave) memory for the avmm_*_rw master port of our HLS components.
//  Serves byte-enabled 64-bit reads/writes with a fixed read latency; there is no waitrequest or readdatavalid.
//  Sits between a component master port and the bench/system as its backing array store (data/cov buffers).
//  A backdoor port lets the bench preload and inspect memory. Counters and sticky error flags aid checking.
// PARAMETERS
//  ADDR_WIDTH    10    word-index bits; depth = 2**ADDR_WIDTH words of 64 bits
//  BASE_ADDR     64'h0 byte address of word 0 (8-byte aligned)
//  READ_LATENCY  1     cycles from read sample to readdata update; legal 1..8
// PORTS
//  clock               in   1           rising-edge clock
//  resetn              in   1           asynchronous, active-low reset
//  avmm_rw_address     in   64          byte address from master
//  avmm_rw_byteenable  in   8           per-byte write enable; bit i -> writedata[8i+7:8i]
//  avmm_rw_read        in   1           read request, sampled every cycle
//  avmm_rw_readdata    out  64          read response
//  avmm_rw_write       in   1           write request, sampled every cycle
//  avmm_rw_writedata   in   64          write data
//  rd_valid            out  1           debug strobe; 1 in the cycle readdata carries a new response
//  bd_we               in   1           backdoor write, full 64-bit word
//  bd_addr             in   ADDR_WIDTH  backdoor word index
//  bd_wdata            in   64          backdoor write data
//  bd_rdata            out  64          mem[bd_addr], registered, 1-cycle latency
//  rd_count            out  32          accepted in-range reads, saturating
//  wr_count            out  32          accepted in-range writes, saturating
//  oob_err             out  1           sticky: out-of-range or misaligned access seen
//  proto_err           out  1           sticky: read and write asserted in the same cycle
// BEHAVIOUR
//  Reset values:
//   - Outputs: readdata, rd_valid, bd_rdata, both counters and both error flags reset to 0.
//   - Memory array is NOT reset; contents persist across resetn.
//   - Latency pipeline is cleared, so reads in flight at reset are dropped (no rd_valid afterwards).
//  Decode:
//   - off = address - BASE_ADDR.
//   - In range iff address >= BASE_ADDR, off < 8*2**ADDR_WIDTH and address[2:0]==0.
//   - Word index = off >> 3.
//  Write: on a clock edge with write=1 and in range, each byte i with byteenable[i]=1 is updated. Other bytes are unchanged.
//   - byteenable=0 is a legal no-op but still counts in wr_count.
//  Read (registered read, then READ_LATENCY-1 pipeline stages):
//   - With read=1 at edge N, readdata and rd_valid update at edge N+READ_LATENCY.
//   - Back-to-back reads are fully pipelined: one response per cycle, in order.
//   - readdata holds its last value when rd_valid=0.
//  Out of range or misaligned:
//   - Write is ignored.
//   - Read returns 64'h0 with normal latency and rd_valid.
//   - oob_err is set; neither counter increments.
//  read and write in the same cycle:
//   - proto_err is set and both are performed.
//   - Read returns the pre-write data (read-before-write).
//  Read-after-write to the same word on consecutive edges: the read returns the new data.
//  Backdoor:
//   - bd_we writes the full word.
//   - If bd_we and an avmm write hit the same word in the same cycle, the avmm write's enabled bytes win; the other bytes take bd_wdata.
//   - bd_rdata is read-before-write, like avmm.
//  Counters saturate at 32'hFFFF_FFFF. The error flags clear only on resetn.
// TESTING
//  1 bd-load word3=64'h1122334455667788, READ_LATENCY=1; read addr 0x18 at edge N -> readdata=0x1122334455667788 and rd_valid=1 at edge N+1; rd_count=1.
//  2 Write addr 0x18 be=8'h0F wdata=64'hAAAAAAAA_BBBBBBBB, then read -> 0x11223344_BBBBBBBB; wr_count=1.
//  3 READ_LATENCY=3: reads of words 0,1,2 on 3 consecutive edges -> 3 consecutive rd_valid cycles starting 3 edges later, data in order.
//  4 Read addr 0x2000 (depth 1024) and addr 0x04 -> readdata=0, oob_err=1, rd_count unchanged; write there leaves memory unchanged.
//  5 read+write of word 5 in the same cycle (old 0x0, new 0xFF) -> read returns 0x0, proto_err=1, next read returns 0xFF.
//  6 Assert resetn=0 while a READ_LATENCY=3 read is in flight -> no rd_valid after release; memory word unchanged.

Source files
------------

// File: rtl/avmm_rw_mem_responder_if.sv
// Avalon-MM read/write bus between an HLS component master port and the
// responder memory. Fixed read latency: no waitrequest, no readdatavalid.
interface avmm_rw_mem_responder_if;
  logic [63:0] avmm_rw_address;
  logic [7:0]  avmm_rw_byteenable;
  logic        avmm_rw_read;
  logic [63:0] avmm_rw_readdata;
  logic        avmm_rw_write;
  logic [63:0] avmm_rw_writedata;

  modport master (
    output avmm_rw_address,
    output avmm_rw_byteenable,
    output avmm_rw_read,
    output avmm_rw_write,
    output avmm_rw_writedata,
    input  avmm_rw_readdata
  );

  modport slave (
    input  avmm_rw_address,
    input  avmm_rw_byteenable,
    input  avmm_rw_read,
    input  avmm_rw_write,
    input  avmm_rw_writedata,
    output avmm_rw_readdata
  );
endinterface

// File: rtl/avmm_rw_mem_responder.sv
// Avalon-MM responder memory: 64-bit words, byte-enabled writes, fixed read
// latency, a backdoor port for preload/inspection, saturating access counters
// and sticky error flags.
module avmm_rw_mem_responder #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  avmm_rw_mem_responder_if.slave avmm,
  output logic                   rd_valid,
  input  logic                   bd_we,
  input  logic [ADDR_WIDTH-1:0]  bd_addr,
  input  logic [63:0]            bd_wdata,
  output logic [63:0]            bd_rdata,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count,
  output logic                   oob_err,
  output logic                   proto_err
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LAT   = READ_LATENCY;

  logic [63:0] mem [DEPTH];

  logic [64:0]           off_full;
  logic [63:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [63:0]           rd_word;
  logic                  rd_hit;
  logic                  wr_hit;

  logic [LAT-1:0] pipe_valid_q, pipe_valid_d;
  logic [63:0]    pipe_data_q [LAT];
  logic [63:0]    pipe_data_d [LAT];
  logic [63:0]    readdata_q, readdata_d;
  logic           rd_valid_q, rd_valid_d;
  logic [63:0]    bd_rdata_q, bd_rdata_d;
  logic [31:0]    rd_count_q, rd_count_d;
  logic [31:0]    wr_count_q, wr_count_d;
  logic           oob_err_q, oob_err_d;
  logic           proto_err_q, proto_err_d;

  // Address decode: the extra top bit of the subtraction is the borrow, which
  // flags addresses below BASE_ADDR without a constant-folded comparison.
  always_comb begin
    off_full = {1'b0, avmm.avmm_rw_address} - {1'b0, BASE_ADDR};
    off      = off_full[63:0];
    in_range = !off_full[64] && (off[63:ADDR_WIDTH+3] == '0) && (off[2:0] == 3'b000);
    word_idx = off[ADDR_WIDTH+2:3];
    rd_hit   = avmm.avmm_rw_read && in_range;
    wr_hit   = avmm.avmm_rw_write && in_range;
    rd_word  = rd_hit ? mem[word_idx] : 64'h0;
  end

  // NOTE: the memory array has no reset branch; its contents must survive
  // resetn, and a reset would also prevent mapping it onto block RAM.
  // Backdoor write first, avmm byte lanes second, so on a same-word collision
  // the later non-blocking assignment (the avmm enabled bytes) wins.
  always_ff @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (wr_hit) begin
      for (int i = 0; i < 8; i++) begin
        if (avmm.avmm_rw_byteenable[i]) mem[word_idx][8*i +: 8] <= avmm.avmm_rw_writedata[8*i +: 8];
      end
    end
  end

  // Next-state for the read pipeline, backdoor read, counters and flags.
  // NOTE: every signal gets its default first so no path can infer a latch.
  always_comb begin
    pipe_valid_d    = pipe_valid_q;
    pipe_data_d     = pipe_data_q;
    pipe_valid_d[0] = avmm.avmm_rw_read;
    pipe_data_d[0]  = rd_word;
    for (int i = 1; i < LAT; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_data_d[i]  = pipe_data_q[i-1];
    end

    rd_valid_d = pipe_valid_q[LAT-1];
    readdata_d = pipe_valid_q[LAT-1] ? pipe_data_q[LAT-1] : readdata_q;
    bd_rdata_d = mem[bd_addr];

    rd_count_d = rd_count_q;
    if (rd_hit && (rd_count_q != 32'hFFFF_FFFF)) rd_count_d = rd_count_q + 32'd1;
    wr_count_d = wr_count_q;
    if (wr_hit && (wr_count_q != 32'hFFFF_FFFF)) wr_count_d = wr_count_q + 32'd1;

    oob_err_d   = oob_err_q | ((avmm.avmm_rw_read | avmm.avmm_rw_write) & !in_range);
    proto_err_d = proto_err_q | (avmm.avmm_rw_read & avmm.avmm_rw_write);
  end

  // State registers; reset drops any reads still in flight.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < LAT; i++) pipe_data_q[i] <= 64'h0;
      readdata_q  <= 64'h0;
      rd_valid_q  <= 1'b0;
      bd_rdata_q  <= 64'h0;
      rd_count_q  <= 32'h0;
      wr_count_q  <= 32'h0;
      oob_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      readdata_q   <= readdata_d;
      rd_valid_q   <= rd_valid_d;
      bd_rdata_q   <= bd_rdata_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      oob_err_q    <= oob_err_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign avmm.avmm_rw_readdata = readdata_q;
  assign rd_valid              = rd_valid_q;
  assign bd_rdata              = bd_rdata_q;
  assign rd_count              = rd_count_q;
  assign wr_count              = wr_count_q;
  assign oob_err               = oob_err_q;
  assign proto_err             = proto_err_q;
endmodule

// File: tb/tb_avmm_rw_mem_responder.sv
// Directed bench for avmm_rw_mem_responder: one instance with READ_LATENCY=1
// and one with READ_LATENCY=3, sharing clock and reset.
module tb_avmm_rw_mem_responder;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  avmm_rw_mem_responder_if if1 ();
  avmm_rw_mem_responder_if if3 ();

  logic        rd_valid1, rd_valid3;
  logic        bd_we1, bd_we3;
  logic [9:0]  bd_addr1, bd_addr3;
  logic [63:0] bd_wdata1, bd_wdata3;
  logic [63:0] bd_rdata1, bd_rdata3;
  logic [31:0] rd_count1, rd_count3, wr_count1, wr_count3;
  logic        oob_err1, oob_err3, proto_err1, proto_err3;

  avmm_rw_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(64'h0), .READ_LATENCY(1)) dut1 (
    .clock(clock), .resetn(resetn), .avmm(if1.slave), .rd_valid(rd_valid1),
    .bd_we(bd_we1), .bd_addr(bd_addr1), .bd_wdata(bd_wdata1), .bd_rdata(bd_rdata1),
    .rd_count(rd_count1), .wr_count(wr_count1), .oob_err(oob_err1), .proto_err(proto_err1)
  );

  avmm_rw_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(64'h0), .READ_LATENCY(3)) dut3 (
    .clock(clock), .resetn(resetn), .avmm(if3.slave), .rd_valid(rd_valid3),
    .bd_we(bd_we3), .bd_addr(bd_addr3), .bd_wdata(bd_wdata3), .bd_rdata(bd_rdata3),
    .rd_count(rd_count3), .wr_count(wr_count3), .oob_err(oob_err3), .proto_err(proto_err3)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input bit s3, input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [7:0] be, input logic [63:0] wd);
    if (s3) begin
      if3.avmm_rw_read = rd; if3.avmm_rw_write = wr; if3.avmm_rw_address = addr;
      if3.avmm_rw_byteenable = be; if3.avmm_rw_writedata = wd;
    end else begin
      if1.avmm_rw_read = rd; if1.avmm_rw_write = wr; if1.avmm_rw_address = addr;
      if1.avmm_rw_byteenable = be; if1.avmm_rw_writedata = wd;
    end
  endtask

  task automatic idle(input bit s3);
    set_req(s3, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0);
  endtask

  task automatic bd_load(input bit s3, input logic [9:0] idx, input logic [63:0] d);
    if (s3) begin bd_we3 = 1'b1; bd_addr3 = idx; bd_wdata3 = d; end
    else    begin bd_we1 = 1'b1; bd_addr1 = idx; bd_wdata1 = d; end
    tick();
    bd_we1 = 1'b0;
    bd_we3 = 1'b0;
  endtask

  task automatic bd_peek(input bit s3, input logic [9:0] idx, output logic [63:0] d);
    if (s3) bd_addr3 = idx; else bd_addr1 = idx;
    tick();
    d = s3 ? bd_rdata3 : bd_rdata1;
  endtask

  task automatic test_reset();
    checks++; if (if1.avmm_rw_readdata !== 64'h0) begin failures++; $display("FAIL reset_readdata1: got %h expected 0", if1.avmm_rw_readdata); end
    checks++; if (rd_valid1 !== 1'b0) begin failures++; $display("FAIL reset_rd_valid1: got %b expected 0", rd_valid1); end
    checks++; if (bd_rdata1 !== 64'h0) begin failures++; $display("FAIL reset_bd_rdata1: got %h expected 0", bd_rdata1); end
    checks++; if (rd_count1 !== 32'h0 || wr_count1 !== 32'h0) begin failures++; $display("FAIL reset_counts1: got rd=%0d wr=%0d expected 0 0", rd_count1, wr_count1); end
    checks++; if (oob_err1 !== 1'b0 || proto_err1 !== 1'b0) begin failures++; $display("FAIL reset_flags1: got oob=%b proto=%b expected 0 0", oob_err1, proto_err1); end
    checks++; if (rd_valid3 !== 1'b0 || if3.avmm_rw_readdata !== 64'h0) begin failures++; $display("FAIL reset_dut3: got valid=%b data=%h expected 0 0", rd_valid3, if3.avmm_rw_readdata); end
  endtask

  task automatic test_read_latency1();
    bd_load(1'b0, 10'd3, 64'h1122334455667788);
    set_req(1'b0, 1'b1, 1'b0, 64'h18, 8'h0, 64'h0);
    tick();
    idle(1'b0);
    checks++; if (rd_valid1 !== 1'b0) begin failures++; $display("FAIL l1_valid_early: got %b expected 0", rd_valid1); end
    tick();
    checks++; if (rd_valid1 !== 1'b1) begin failures++; $display("FAIL l1_valid: got %b expected 1", rd_valid1); end
    checks++; if (if1.avmm_rw_readdata !== 64'h1122334455667788) begin failures++; $display("FAIL l1_data: got %h expected 1122334455667788", if1.avmm_rw_readdata); end
    checks++; if (rd_count1 !== 32'd1) begin failures++; $display("FAIL l1_rd_count: got %0d expected 1", rd_count1); end
    tick();
    checks++; if (rd_valid1 !== 1'b0 || if1.avmm_rw_readdata !== 64'h1122334455667788) begin failures++; $display("FAIL l1_hold: got valid=%b data=%h expected 0 1122334455667788", rd_valid1, if1.avmm_rw_readdata); end
  endtask

  task automatic test_byte_write();
    logic [63:0] d;
    set_req(1'b0, 1'b0, 1'b1, 64'h18, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    tick();
    idle(1'b0);
    checks++; if (wr_count1 !== 32'd1) begin failures++; $display("FAIL bw_wr_count: got %0d expected 1", wr_count1); end
    set_req(1'b0, 1'b1, 1'b0, 64'h18, 8'h0, 64'h0);
    tick();
    idle(1'b0);
    tick();
    checks++; if (if1.avmm_rw_readdata !== 64'h11223344_BBBBBBBB) begin failures++; $display("FAIL bw_data: got %h expected 11223344bbbbbbbb", if1.avmm_rw_readdata); end
    checks++; if (rd_count1 !== 32'd2) begin failures++; $display("FAIL bw_rd_count: got %0d expected 2", rd_count1); end
    set_req(1'b0, 1'b0, 1'b1, 64'h18, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    idle(1'b0);
    checks++; if (wr_count1 !== 32'd2) begin failures++; $display("FAIL bw_be0_count: got %0d expected 2", wr_count1); end
    bd_peek(1'b0, 10'd3, d);
    checks++; if (d !== 64'h11223344_BBBBBBBB) begin failures++; $display("FAIL bw_be0_data: got %h expected 11223344bbbbbbbb", d); end
  endtask

  task automatic test_pipeline();
    logic [63:0] exp [3];
    exp[0] = 64'hA0A0_0000_0000_0001;
    exp[1] = 64'hA1A1_0000_0000_0002;
    exp[2] = 64'hA2A2_0000_0000_0003;
    for (int k = 0; k < 3; k++) bd_load(1'b1, 10'(k), exp[k]);
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'b1, 1'b0, 64'(8 * k), 8'h0, 64'h0);
      tick();
    end
    idle(1'b1);
    checks++; if (rd_valid3 !== 1'b0) begin failures++; $display("FAIL l3_valid_early: got %b expected 0", rd_valid3); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (rd_valid3 !== 1'b1 || if3.avmm_rw_readdata !== exp[k]) begin
        failures++; $display("FAIL l3_resp%0d: got valid=%b data=%h expected 1 %h", k, rd_valid3, if3.avmm_rw_readdata, exp[k]);
      end
    end
    tick();
    checks++; if (rd_valid3 !== 1'b0 || if3.avmm_rw_readdata !== exp[2]) begin failures++; $display("FAIL l3_hold: got valid=%b data=%h expected 0 %h", rd_valid3, if3.avmm_rw_readdata, exp[2]); end
    checks++; if (rd_count3 !== 32'd3) begin failures++; $display("FAIL l3_rd_count: got %0d expected 3", rd_count3); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] d;
    bd_load(1'b0, 10'd0, 64'hDEAD_BEEF_0000_0001);
    checks++; if (oob_err1 !== 1'b0) begin failures++; $display("FAIL oob_pre: got %b expected 0", oob_err1); end
    // Last word of the array is still in range.
    set_req(1'b0, 1'b0, 1'b1, 64'h1FF8, 8'hFF, 64'h0123456789ABCDEF);
    tick();
    set_req(1'b0, 1'b1, 1'b0, 64'h1FF8, 8'h0, 64'h0);
    tick();
    idle(1'b0);
    tick();
    checks++; if (if1.avmm_rw_readdata !== 64'h0123456789ABCDEF || oob_err1 !== 1'b0) begin failures++; $display("FAIL oob_last_word: got data=%h oob=%b expected 0123456789abcdef 0", if1.avmm_rw_readdata, oob_err1); end
    checks++; if (rd_count1 !== 32'd3 || wr_count1 !== 32'd3) begin failures++; $display("FAIL oob_last_counts: got rd=%0d wr=%0d expected 3 3", rd_count1, wr_count1); end
    // Misaligned read.
    set_req(1'b0, 1'b1, 1'b0, 64'h04, 8'h0, 64'h0);
    tick();
    idle(1'b0);
    tick();
    checks++; if (rd_valid1 !== 1'b1 || if1.avmm_rw_readdata !== 64'h0) begin failures++; $display("FAIL oob_misaligned_rd: got valid=%b data=%h expected 1 0", rd_valid1, if1.avmm_rw_readdata); end
    checks++; if (oob_err1 !== 1'b1 || rd_count1 !== 32'd3) begin failures++; $display("FAIL oob_misaligned_flag: got oob=%b rd=%0d expected 1 3", oob_err1, rd_count1); end
    // Reload a non-zero response, then read one word past the end.
    set_req(1'b0, 1'b1, 1'b0, 64'h1FF8, 8'h0, 64'h0);
    tick();
    set_req(1'b0, 1'b1, 1'b0, 64'h2000, 8'h0, 64'h0);
    tick();
    idle(1'b0);
    tick();
    checks++; if (rd_valid1 !== 1'b1 || if1.avmm_rw_readdata !== 64'h0 || rd_count1 !== 32'd4) begin failures++; $display("FAIL oob_past_end_rd: got valid=%b data=%h rd=%0d expected 1 0 4", rd_valid1, if1.avmm_rw_readdata, rd_count1); end
    // Out-of-range writes must leave memory untouched.
    set_req(1'b0, 1'b0, 1'b1, 64'h2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    set_req(1'b0, 1'b0, 1'b1, 64'h04, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    idle(1'b0);
    checks++; if (wr_count1 !== 32'd3) begin failures++; $display("FAIL oob_wr_count: got %0d expected 3", wr_count1); end
    bd_peek(1'b0, 10'd0, d);
    checks++; if (d !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL oob_word0: got %h expected deadbeef00000001", d); end
    bd_peek(1'b0, 10'd1023, d);
    checks++; if (d !== 64'h0123456789ABCDEF) begin failures++; $display("FAIL oob_word1023: got %h expected 0123456789abcdef", d); end
  endtask

  task automatic test_proto();
    checks++; if (proto_err1 !== 1'b0) begin failures++; $display("FAIL proto_pre: got %b expected 0", proto_err1); end
    bd_load(1'b0, 10'd5, 64'h0);
    set_req(1'b0, 1'b1, 1'b0, 64'h18, 8'h0, 64'h0);
    tick();
    set_req(1'b0, 1'b1, 1'b1, 64'h28, 8'hFF, 64'hFF);
    tick();
    idle(1'b0);
    checks++; if (proto_err1 !== 1'b1) begin failures++; $display("FAIL proto_flag: got %b expected 1", proto_err1); end
    tick();
    checks++; if (rd_valid1 !== 1'b1 || if1.avmm_rw_readdata !== 64'h0) begin failures++; $display("FAIL proto_rbw: got valid=%b data=%h expected 1 0", rd_valid1, if1.avmm_rw_readdata); end
    set_req(1'b0, 1'b1, 1'b0, 64'h28, 8'h0, 64'h0);
    tick();
    idle(1'b0);
    tick();
    checks++; if (if1.avmm_rw_readdata !== 64'hFF) begin failures++; $display("FAIL proto_after: got %h expected ff", if1.avmm_rw_readdata); end
    checks++; if (rd_count1 !== 32'd7 || wr_count1 !== 32'd4) begin failures++; $display("FAIL proto_counts: got rd=%0d wr=%0d expected 7 4", rd_count1, wr_count1); end
  endtask

  task automatic test_back_to_back();
    // Write at one edge, read the same word at the next.
    set_req(1'b0, 1'b0, 1'b1, 64'h30, 8'hFF, 64'hCAFE_F00D_1234_5678);
    tick();
    set_req(1'b0, 1'b1, 1'b0, 64'h30, 8'h0, 64'h0);
    tick();
    idle(1'b0);
    tick();
    checks++; if (if1.avmm_rw_readdata !== 64'hCAFE_F00D_1234_5678) begin failures++; $display("FAIL raw_data: got %h expected cafef00d12345678", if1.avmm_rw_readdata); end
    set_req(1'b0, 1'b1, 1'b0, 64'h18, 8'h0, 64'h0);
    tick();
    set_req(1'b0, 1'b1, 1'b0, 64'h28, 8'h0, 64'h0);
    tick();
    idle(1'b0);
    checks++; if (rd_valid1 !== 1'b1 || if1.avmm_rw_readdata !== 64'h11223344_BBBBBBBB) begin failures++; $display("FAIL b2b_first: got valid=%b data=%h expected 1 11223344bbbbbbbb", rd_valid1, if1.avmm_rw_readdata); end
    tick();
    checks++; if (rd_valid1 !== 1'b1 || if1.avmm_rw_readdata !== 64'hFF) begin failures++; $display("FAIL b2b_second: got valid=%b data=%h expected 1 ff", rd_valid1, if1.avmm_rw_readdata); end
    checks++; if (rd_count1 !== 32'd10 || wr_count1 !== 32'd5) begin failures++; $display("FAIL b2b_counts: got rd=%0d wr=%0d expected 10 5", rd_count1, wr_count1); end
  endtask

  task automatic test_backdoor_collision();
    logic [63:0] d;
    bd_load(1'b0, 10'd7, 64'h7777_7777_7777_7777);
    bd_we1 = 1'b1; bd_addr1 = 10'd7; bd_wdata1 = 64'h1111_1111_1111_1111;
    set_req(1'b0, 1'b0, 1'b1, 64'h38, 8'hF0, 64'h2222_2222_3333_3333);
    tick();
    bd_we1 = 1'b0;
    idle(1'b0);
    checks++; if (bd_rdata1 !== 64'h7777_7777_7777_7777) begin failures++; $display("FAIL bd_rbw: got %h expected 7777777777777777", bd_rdata1); end
    bd_peek(1'b0, 10'd7, d);
    checks++; if (d !== 64'h2222_2222_1111_1111) begin failures++; $display("FAIL bd_collision: got %h expected 2222222211111111", d); end
    checks++; if (wr_count1 !== 32'd6) begin failures++; $display("FAIL bd_wr_count: got %0d expected 6", wr_count1); end
  endtask

  task automatic test_reset_inflight();
    logic [63:0] d;
    bit seen;
    bd_load(1'b1, 10'd4, 64'h4444_5555_6666_7777);
    set_req(1'b1, 1'b1, 1'b0, 64'h20, 8'h0, 64'h0);
    tick();
    idle(1'b1);
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rd_valid3 === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_dropped: got rd_valid seen=%b expected 0", seen); end
    checks++; if (if3.avmm_rw_readdata !== 64'h0 || rd_count3 !== 32'd0) begin failures++; $display("FAIL rst_state3: got data=%h rd=%0d expected 0 0", if3.avmm_rw_readdata, rd_count3); end
    bd_peek(1'b1, 10'd4, d);
    checks++; if (d !== 64'h4444_5555_6666_7777) begin failures++; $display("FAIL rst_mem_kept: got %h expected 4444555566667777", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(1'b0);
    idle(1'b1);
    bd_we1 = 1'b0; bd_addr1 = '0; bd_wdata1 = '0;
    bd_we3 = 1'b0; bd_addr3 = '0; bd_wdata3 = '0;
    resetn = 1'b0;
    tick();
    tick();
    test_reset();
    resetn = 1'b1;
    tick();
    test_read_latency1();
    test_byte_write();
    test_pipeline();
    test_out_of_range();
    test_proto();
    test_back_to_back();
    test_backdoor_collision();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
